// File: rtl/cnn_window_gen_pkg.sv
// Shared kernel/image geometry defaults, FSM encoding and counter-width helper for the window generator.
package cnn_window_gen_pkg;

  localparam int KX_DEF     = 3;
  localparam int KY_DEF     = 3;
  localparam int I_F_BW_DEF = 8;
  localparam int IX_DEF     = 16;
  localparam int IY_DEF     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter width for values 0..n-1; a 1-entry range still needs one bit.
  function automatic int cnt_bw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_line_buffer.sv
// One image line of pixels addressed by column; combinational read returns the old entry,
// so a write in the same cycle is read-before-write.
module cnn_line_buffer
  import cnn_window_gen_pkg::*;
#(
  parameter int DEPTH = IX_DEF,
  parameter int W     = I_F_BW_DEF,
  parameter int AW    = cnt_bw(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wr_dat,
  output logic [W-1:0]  rd_dat
);

  logic [W-1:0] mem [DEPTH];

  assign rd_dat = mem[addr];

  always_ff @(posedge clk) begin
    if (en) mem[addr] <= wr_dat;
  end

endmodule

// File: rtl/cnn_window_gen.sv
// Raster pixel stream to KX x KY sliding window (valid convolution, stride 1); window out 1 cycle after
// its completing pixel; no backpressure, every valid pixel in RUN is consumed.
module cnn_window_gen
  import cnn_window_gen_pkg::*;
#(
  parameter int KX     = KX_DEF,
  parameter int KY     = KY_DEF,
  parameter int I_F_BW = I_F_BW_DEF,
  parameter int IX     = IX_DEF,
  parameter int IY     = IY_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_soft_reset,
  input  logic                     i_start,
  input  logic                     i_in_valid,
  input  logic [I_F_BW-1:0]        i_in_pixel,
  output logic                     o_busy,
  output logic                     o_ot_valid,
  output logic [KX*KY*I_F_BW-1:0]  o_ot_fmap,
  output logic                     o_done
);

  localparam int COL_BW  = cnt_bw(IX);
  localparam int ROW_BW  = cnt_bw(IY);
  localparam int FMAP_BW = KX*KY*I_F_BW;

  state_t             state, state_nxt;
  logic [COL_BW-1:0]  col;
  logic [ROW_BW-1:0]  row;
  logic               clr;
  logic               accept;
  logic               col_last;
  logic               row_last;
  logic               win_ok;

  logic [I_F_BW-1:0]  lb_rd   [KY-1];
  logic [I_F_BW-1:0]  col_vec [KY];
  logic [I_F_BW-1:0]  win     [KY][KX];
  logic [I_F_BW-1:0]  win_nxt [KY][KX];
  logic [FMAP_BW-1:0] fmap_nxt;

  assign clr      = reset | i_soft_reset;
  assign accept   = (state == ST_RUN) & i_in_valid;
  assign col_last = (col == COL_BW'(IX-1));
  assign row_last = (row == ROW_BW'(IY-1));
  assign win_ok   = (row >= ROW_BW'(KY-1)) & (col >= COL_BW'(KX-1));
  assign o_busy   = (state != ST_IDLE);

  // Line j holds the image line that is KY-1-j lines older than the incoming one (j=0 oldest).
  for (genvar j = 0; j < KY-1; j++) begin : g_line
    cnn_line_buffer #(
      .DEPTH (IX),
      .W     (I_F_BW),
      .AW    (COL_BW)
    ) u_line (
      .clk    (clk),
      .en     (accept),
      .addr   (col),
      .wr_dat (col_vec[j+1]),
      .rd_dat (lb_rd[j])
    );
  end

  always_comb begin
    for (int k = 0; k < KY-1; k++) col_vec[k] = lb_rd[k];
    col_vec[KY-1] = i_in_pixel;
  end

  always_comb begin
    fmap_nxt = '0;
    for (int ky = 0; ky < KY; ky++) begin
      for (int kx = 0; kx < KX-1; kx++) win_nxt[ky][kx] = win[ky][kx+1];
      win_nxt[ky][KX-1] = col_vec[ky];
      for (int kx = 0; kx < KX; kx++) fmap_nxt[(ky*KX+kx)*I_F_BW +: I_F_BW] = win_nxt[ky][kx];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (i_start) state_nxt = ST_RUN;
      ST_RUN:  if (accept && col_last && row_last) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // The output fmap is loaded only at valid positions so it holds the last window between pulses.
  always_ff @(posedge clk) begin
    if (clr) begin
      col        <= '0;
      row        <= '0;
      win        <= '{default: '0};
      o_ot_valid <= 1'b0;
      o_ot_fmap  <= '0;
      o_done     <= 1'b0;
    end else begin
      o_ot_valid <= accept & win_ok;
      o_done     <= (state == ST_DONE);
      if (accept) begin
        win <= win_nxt;
        if (win_ok) o_ot_fmap <= fmap_nxt;
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + ROW_BW'(1);
        end else begin
          col <= col + COL_BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cnn_window_gen.sv
// Directed bench for cnn_window_gen: 4x4 image instance plus a 5x3 instance on shared inputs.
module tb_cnn_window_gen;
  import cnn_window_gen_pkg::*;

  localparam int W = 72;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic soft_reset = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_pixel = '0;

  logic busy_a, ot_valid_a, done_a;
  logic [W-1:0] ot_fmap_a;
  logic busy_b, ot_valid_b, done_b;
  logic [W-1:0] ot_fmap_b;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [W-1:0] wq_a[$];
  int wc_a[$];
  int done_n_a = 0;
  int done_c_a = 0;
  logic [W-1:0] wq_b[$];
  int done_n_b = 0;
  int pix_cyc[16];

  cnn_window_gen #(.KX(3), .KY(3), .I_F_BW(8), .IX(4), .IY(4)) dut_a (
    .clk(clk), .reset(reset), .i_soft_reset(soft_reset), .i_start(start),
    .i_in_valid(in_valid), .i_in_pixel(in_pixel), .o_busy(busy_a),
    .o_ot_valid(ot_valid_a), .o_ot_fmap(ot_fmap_a), .o_done(done_a)
  );

  cnn_window_gen #(.KX(3), .KY(3), .I_F_BW(8), .IX(5), .IY(3)) dut_b (
    .clk(clk), .reset(reset), .i_soft_reset(soft_reset), .i_start(start),
    .i_in_valid(in_valid), .i_in_pixel(in_pixel), .o_busy(busy_b),
    .o_ot_valid(ot_valid_b), .o_ot_fmap(ot_fmap_b), .o_done(done_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ot_valid_a) begin
      wq_a.push_back(ot_fmap_a);
      wc_a.push_back(cyc);
    end
    if (done_a) begin
      done_n_a++;
      done_c_a = cyc;
    end
    if (ot_valid_b) wq_b.push_back(ot_fmap_b);
    if (done_b) done_n_b++;
  end

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack9(input int e0, input int e1, input int e2,
                                         input int e3, input int e4, input int e5,
                                         input int e6, input int e7, input int e8);
    logic [W-1:0] r;
    r = {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    return r;
  endfunction

  // 3x3 window of a 4-wide image whose top-left pixel value is b+s.
  function automatic logic [W-1:0] win4(input int b, input int s);
    int t;
    t = b + s;
    return pack9(t, t+1, t+2, t+4, t+5, t+6, t+8, t+9, t+10);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wq_a.delete();
    wc_a.delete();
    wq_b.delete();
    done_n_a = 0;
    done_c_a = 0;
    done_n_b = 0;
  endtask

  task automatic start_frame();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_pixels(input int base, input int n, input bit gaps, input int start_at);
    for (int i = 0; i < n; i++) begin
      step();
      in_valid = 1'b1;
      in_pixel = 8'(base + i);
      start = (i == start_at);
      if (i < 16) pix_cyc[i] = cyc;
      if (gaps) begin
        step();
        in_valid = 1'b0;
        start = 1'b0;
      end
    end
    step();
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit sel_b, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if ((sel_b ? done_b : done_a) === 1'b1) seen = 1'b1;
      else step();
    end
    chk(tag, seen, 1'b1);
  endtask

  task automatic soft_pulse();
    step();
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
  endtask

  task automatic check_frame4(input string tag, input int base);
    chk({tag, "_nwin"}, wq_a.size(), 4);
    if (wq_a.size() == 4) begin
      chk({tag, "_w0"}, wq_a[0], win4(base, 0));
      chk({tag, "_w1"}, wq_a[1], win4(base, 1));
      chk({tag, "_w2"}, wq_a[2], win4(base, 4));
      chk({tag, "_w3"}, wq_a[3], win4(base, 5));
      chk({tag, "_done_after_last"}, done_c_a, wc_a[3] + 1);
    end
    chk({tag, "_ndone"}, done_n_a, 1);
  endtask

  initial begin
    // 1: reset
    step();
    step();
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_valid", ot_valid_a, 1'b0);
    chk("rst_fmap", ot_fmap_a, '0);
    chk("rst_done", done_a, 1'b0);
    reset = 1'b0;

    // 2: back-to-back frame 0..15
    clear_mon();
    start_frame();
    chk("t2_busy", busy_a, 1'b1);
    send_pixels(0, 16, 1'b0, -1);
    wait_done(1'b0, "t2_done_seen");
    step();
    check_frame4("t2", 0);
    if (wq_a.size() == 4) begin
      chk("t2_first_lit", wq_a[0], pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
      chk("t2_last_lit", wq_a[3], pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));
      chk("t2_lat_first", wc_a[0], pix_cyc[10] + 1);
      chk("t2_lat_last", wc_a[3], pix_cyc[15] + 1);
    end
    chk("t2_hold_fmap", ot_fmap_a, pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));
    chk("t2_idle_busy", busy_a, 1'b0);

    // 3: valid low every other cycle
    clear_mon();
    start_frame();
    send_pixels(0, 16, 1'b1, -1);
    wait_done(1'b0, "t3_done_seen");
    step();
    check_frame4("t3", 0);
    if (wq_a.size() == 4) chk("t3_spacing", wc_a[1] - wc_a[0], 2);

    // 4: pixels in IDLE and i_start during RUN are ignored
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      step();
      in_valid = 1'b1;
      in_pixel = 8'(200 + i);
    end
    step();
    in_valid = 1'b0;
    chk("t4_idle_busy", busy_a, 1'b0);
    start_frame();
    send_pixels(0, 16, 1'b0, 6);
    wait_done(1'b0, "t4_done_seen");
    step();
    check_frame4("t4", 0);

    // 5: soft reset mid-frame, then fresh frame 100..115
    clear_mon();
    start_frame();
    send_pixels(0, 10, 1'b0, -1);
    soft_pulse();
    chk("t5_sr_busy", busy_a, 1'b0);
    chk("t5_sr_valid", ot_valid_a, 1'b0);
    chk("t5_sr_fmap", ot_fmap_a, '0);
    chk("t5_sr_nwin", wq_a.size(), 0);
    start_frame();
    send_pixels(100, 16, 1'b0, -1);
    wait_done(1'b0, "t5_done_seen");
    step();
    check_frame4("t5", 100);
    if (wq_a.size() > 0) chk("t5_first_lit", wq_a[0], pack9(100, 101, 102, 104, 105, 106, 108, 109, 110));

    // 6: two frames back-to-back, restart in the cycle after o_done
    clear_mon();
    start_frame();
    send_pixels(0, 16, 1'b0, -1);
    wait_done(1'b0, "t6_done1_seen");
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    send_pixels(50, 16, 1'b0, -1);
    wait_done(1'b0, "t6_done2_seen");
    step();
    chk("t6_nwin", wq_a.size(), 8);
    chk("t6_ndone", done_n_a, 2);
    if (wq_a.size() == 8) begin
      chk("t6_w3", wq_a[3], pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));
      chk("t6_w4", wq_a[4], pack9(50, 51, 52, 54, 55, 56, 58, 59, 60));
      chk("t6_w7", wq_a[7], pack9(55, 56, 57, 59, 60, 61, 63, 64, 65));
    end

    // 6b: 5x3 image on the second instance
    soft_pulse();
    clear_mon();
    start_frame();
    send_pixels(0, 15, 1'b0, -1);
    wait_done(1'b1, "t6b_done_seen");
    step();
    chk("t6b_nwin", wq_b.size(), 3);
    chk("t6b_ndone", done_n_b, 1);
    if (wq_b.size() == 3) begin
      chk("t6b_w0", wq_b[0], pack9(0, 1, 2, 5, 6, 7, 10, 11, 12));
      chk("t6b_w2", wq_b[2], pack9(2, 3, 4, 7, 8, 9, 12, 13, 14));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
